// File: rtl/corr_pkg.sv
// Shared types and width helpers for the correlation accumulator slice.
// The struct typedefs describe the default build; the top re-derives them for its own parameters.
package corr_pkg;

  localparam int DEF_PIXEL_SIZE    = 8;
  localparam int DEF_NUM_TEMPLATES = 4;
  localparam int DEF_WINDOW_PIXELS = 64;

  // Wide enough that a full window of full-scale beats can never wrap.
  function automatic int acc_width(input int pixel_size, input int window_pixels);
    return 2 * pixel_size + $clog2(window_pixels);
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_PIXEL_SIZE, DEF_WINDOW_PIXELS);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    STALL = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic [2*DEF_PIXEL_SIZE-1:0]                         i;
    logic [2*DEF_PIXEL_SIZE-1:0]                         i2;
    logic [DEF_NUM_TEMPLATES-1:0][2*DEF_PIXEL_SIZE-1:0]  ti;
  } corr_beat_t;

  typedef struct packed {
    logic [DEF_ACC_W-1:0]                         sum_i;
    logic [DEF_ACC_W-1:0]                         sum_i2;
    logic [DEF_NUM_TEMPLATES-1:0][DEF_ACC_W-1:0]  sum_ti;
  } corr_sums_t;

endpackage

// File: rtl/corr_best_select.sv
// Argmax over the per-template window sums; ties resolve to the lowest index.
module corr_best_select
  import corr_pkg::*;
#(
  parameter int NUM_TEMPLATES = DEF_NUM_TEMPLATES,
  parameter int ACC_W         = DEF_ACC_W
) (
  input  logic [NUM_TEMPLATES-1:0][ACC_W-1:0]  sums,
  output logic [$clog2(NUM_TEMPLATES)-1:0]     best_idx,
  output logic [ACC_W-1:0]                     best_sum
);

  localparam int IDX_W = $clog2(NUM_TEMPLATES);

  // Strict greater-than keeps the earlier index on equal sums.
  always_comb begin
    best_idx = '0;
    best_sum = sums[0];
    for (int t = 1; t < NUM_TEMPLATES; t++) begin
      if (sums[t] > best_sum) begin
        best_idx = IDX_W'(t);
        best_sum = sums[t];
      end
    end
  end

endmodule

// File: rtl/correlation_accumulator.sv
// Window accumulator for I, I^2 and T*I with a one-deep output buffer and backpressure.
// Optional best-template select is enabled with `define CORR_ACC_BEST_EN.
module correlation_accumulator
  import corr_pkg::*;
#(
  parameter  int PIXEL_SIZE    = DEF_PIXEL_SIZE,
  parameter  int NUM_TEMPLATES = DEF_NUM_TEMPLATES,
  parameter  int WINDOW_PIXELS = DEF_WINDOW_PIXELS,
  localparam int ACC_W         = acc_width(PIXEL_SIZE, WINDOW_PIXELS)
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     abort,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [2*PIXEL_SIZE-1:0]                  I_in,
  input  logic [2*PIXEL_SIZE-1:0]                  I_square_in,
  input  logic [NUM_TEMPLATES-1:0][2*PIXEL_SIZE-1:0] T_x_I_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ACC_W-1:0]                         sum_I,
  output logic [ACC_W-1:0]                         sum_I2,
  output logic [NUM_TEMPLATES-1:0][ACC_W-1:0]      sum_TI
`ifdef CORR_ACC_BEST_EN
  ,
  output logic [$clog2(NUM_TEMPLATES)-1:0]         best_idx,
  output logic [ACC_W-1:0]                         best_sum
`endif
);

  localparam int                IN_W     = 2 * PIXEL_SIZE;
  localparam int                CNT_W    = $clog2(WINDOW_PIXELS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW_PIXELS - 1);

  typedef struct packed {
    logic [ACC_W-1:0]                     s_i;
    logic [ACC_W-1:0]                     s_i2;
    logic [NUM_TEMPLATES-1:0][ACC_W-1:0]  s_ti;
  } sums_t;

  acc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  sums_t             acc_q, acc_d;
  sums_t             res_q, res_d;
  logic              out_valid_q, out_valid_d;
  sums_t             beat_sum;
  logic              beat_fire, out_fire, buf_free, is_last;
  logic              unused_i_hi;

  assign unused_i_hi = ^I_in[IN_W-1:PIXEL_SIZE];

  assign in_ready  = (state_q == ACCUM);
  assign beat_fire = in_valid && in_ready && !abort;
  assign out_fire  = out_valid_q && out_ready;
  assign buf_free  = !out_valid_q || out_ready;
  assign is_last   = (cnt_q == LAST_CNT);

  // Running sums including the current beat; the first beat of a window replaces stale contents.
  always_comb begin
    beat_sum.s_i  = ACC_W'(I_in[PIXEL_SIZE-1:0]);
    beat_sum.s_i2 = ACC_W'(I_square_in);
    for (int t = 0; t < NUM_TEMPLATES; t++) begin
      beat_sum.s_ti[t] = ACC_W'(T_x_I_in[t]);
    end
    if (cnt_q != '0) begin
      beat_sum.s_i  = beat_sum.s_i + acc_q.s_i;
      beat_sum.s_i2 = beat_sum.s_i2 + acc_q.s_i2;
      for (int t = 0; t < NUM_TEMPLATES; t++) begin
        beat_sum.s_ti[t] = beat_sum.s_ti[t] + acc_q.s_ti[t];
      end
    end
  end

  // NOTE: every output of this block is given a hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      ACCUM: begin
        if (abort) begin
          cnt_d = '0;
        end else if (beat_fire) begin
          if (!is_last) begin
            acc_d = beat_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end else if (buf_free) begin
            res_d       = beat_sum;
            out_valid_d = 1'b1;
            cnt_d       = '0;
          end else begin
            acc_d   = beat_sum;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // The buffer is always occupied here, so a handshake frees it for the held window.
        if (abort) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end else if (out_fire) begin
          res_d       = acc_q;
          out_valid_d = 1'b1;
          state_d     = ACCUM;
          cnt_d       = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_I     = res_q.s_i;
  assign sum_I2    = res_q.s_i2;
  assign sum_TI    = res_q.s_ti;

`ifdef CORR_ACC_BEST_EN
  logic [$clog2(NUM_TEMPLATES)-1:0]  best_idx_q, best_idx_d;
  logic [ACC_W-1:0]                  best_sum_q, best_sum_d;

  // Selecting on the next output value keeps the winner aligned with the result registers.
  corr_best_select #(
    .NUM_TEMPLATES (NUM_TEMPLATES),
    .ACC_W         (ACC_W)
  ) u_best_select (
    .sums     (res_d.s_ti),
    .best_idx (best_idx_d),
    .best_sum (best_sum_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      best_idx_q <= '0;
      best_sum_q <= '0;
    end else begin
      best_idx_q <= best_idx_d;
      best_sum_q <= best_sum_d;
    end
  end

  assign best_idx = best_idx_q;
  assign best_sum = best_sum_q;
`endif

endmodule

// File: doc/correlation_accumulator.md
Name: correlation_accumulator

Overview:
- Consumes the per-pixel correlation stream: I, I², and T×I for each template.
- Sums each quantity over a fixed window of WINDOW_PIXELS accepted beats.
- Presents registered window sums to the normalisation/score stage over a valid/ready handshake.
- Sits between the correlation cell array and the NCC score divider; double-buffered so input continues while a result waits.

Parameters:
- PIXEL_SIZE, 8, pixel bit width; stream fields are 2*PIXEL_SIZE wide.
- NUM_TEMPLATES, 4, number of templates correlated in parallel.
- WINDOW_PIXELS, 64, beats per window; minimum 2.
- ACC_W, 2*PIXEL_SIZE+$clog2(WINDOW_PIXELS), accumulator/result width; derived, not overridable.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- abort  in  1  synchronous window discard.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- I_in  in  2*PIXEL_SIZE  pixel value, zero-extended; upper PIXEL_SIZE bits ignored.
- I_square_in  in  2*PIXEL_SIZE  I².
- T_x_I_in  in  [NUM_TEMPLATES][2*PIXEL_SIZE]  per-template product.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- sum_I  out  ACC_W  ΣI over window.
- sum_I2  out  ACC_W  ΣI².
- sum_TI  out  [NUM_TEMPLATES][ACC_W]  ΣT×I per template.

Behaviour:
- Reset: all accumulators, beat counter, out_valid, sum_I, sum_I2 and all sum_TI go to 0; state goes to ACCUM.
- in_ready is high out of reset.
- FSM states:
  - ACCUM: accept beats.
  - STALL: window complete, output buffer still occupied.
- ACCUM, accepted beat, cnt<WINDOW_PIXELS-1:
  - acc += zero-extended inputs; cnt++.
  - On the first beat (cnt==0) the accumulators are loaded rather than added to.
- ACCUM, accepted beat, cnt==WINDOW_PIXELS-1:
  - If output buffer free, or freed this cycle (out_valid&&out_ready): final sums (acc + beat) go to the output registers; out_valid=1 next cycle; cnt=0.
  - Latency: last beat accepted at cycle N, result visible at N+1.
  - Otherwise: final sums stay in acc, go to STALL, in_ready=0.
- STALL:
  - in_ready=0.
  - When out_ready is seen with out_valid: acc moves to the output registers, out_valid stays 1, cnt=0, return to ACCUM.
  - in_ready returns high the cycle after.
- out_valid drops the cycle after a handshake unless a new result is loaded that same cycle; back-to-back windows produce consecutive results with no bubble.
- Output registers are stable while out_valid && !out_ready.
- abort, ACCUM: cnt=0 and the in-flight beat is discarded.
- abort, STALL: discards the held window and returns to ACCUM.
- abort never touches the output buffer.
- abort has priority over a same-cycle beat.
- Arithmetic:
  - Unsigned, no saturation.
  - ACC_W guarantees no overflow for full-scale input over the window: 255²·64=4161600 < 2²².
- RST mid-window: immediate clear, and any pending result is lost.

Optional Feature:
- Macro: CORR_ACC_BEST_EN.
- When defined:
  - Adds output best_idx [$clog2(NUM_TEMPLATES)] and a registered best_sum [ACC_W].
  - These give the template with the largest sum_TI, updated with the output registers; ties go to the lowest index.
  - The compare tree is computed combinationally on the final sums before registering, so latency is unchanged.
  - Both reset to 0.
- When undefined: ports absent, no compare logic.

Decomposition:
- Shared package corr_pkg holds:
  - PIXEL_SIZE and NUM_TEMPLATES defaults.
  - ACC_W derivation function.
  - typedef corr_beat_t (I, I², T×I array).
  - typedef corr_sums_t (sum_I, sum_I2, sum_TI array).
  - typedef acc_state_e {ACCUM, STALL}.
- One sub-module, corr_best_select: argmax over NUM_TEMPLATES sums, lowest-index tie-break; instantiated only under CORR_ACC_BEST_EN.

Test Plan (PIXEL_SIZE=8, NUM_TEMPLATES=2, WINDOW_PIXELS=4 unless noted):
- Basic window:
  - Stimulus: I=1,2,3,4; T0=1; T1=2; out_ready=1.
  - Response: one cycle after beat 4, out_valid=1, sum_I=10, sum_I2=30, sum_TI={10,20}.
- Back-to-back windows:
  - Stimulus: 8 continuous beats of I=5 (T0=T1=1), out_ready=1.
  - Response: two results of sum_I=20, sum_I2=100, sum_TI={20,20}; in_ready never drops.
- Backpressure:
  - Stimulus: out_ready=0 across two full windows.
  - Response: in_ready=0 after the 8th beat, first result held stable.
  - Then pulse out_ready: the second result loads immediately, and in_ready rises the next cycle.
- Abort:
  - Stimulus: 2 beats of I=7, then abort, then a fresh window I=1,1,1,1.
  - Response: sum_I=4; the aborted beats do not contribute.
- Full scale (WINDOW_PIXELS=64):
  - Stimulus: all beats I=255, T=255.
  - Response: sum_I2=sum_TI=4161600, sum_I=16320, no wrap.
- Reset and best-select:
  - Stimulus: assert RST mid-window, then replay the basic window.
  - Response: all outputs 0 during reset, then a correct result.
  - With CORR_ACC_BEST_EN, T0=T1=3: best_idx=0 (tie goes to the lowest index).
